// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter that splits 16-bit i/d word requests into two
//            byte transactions (low byte first) on a shared byte-wide memory.
// Revision : 1.0
// ============================================================================
module mem_arbiter (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ack,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic        m_ready,
    input  logic [7:0]  m_rdata
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_lo   = 2'd1;
    localparam logic [1:0] c_st_hi   = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_sel_d;
    logic        r_last_d;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [7:0]  r_rbuf_lo;
    logic [15:0] r_i_rdata;
    logic [15:0] r_d_rdata;
    logic        w_grant;
    logic        w_grant_d;

    // On a tie the side that was not served last wins.
    always_comb begin
        w_grant   = i_req | d_req;
        w_grant_d = d_req & (~i_req | ~r_last_d);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_grant) w_next_state = c_st_lo;
            c_st_lo:   if (m_ready) w_next_state = c_st_hi;
            c_st_hi:   if (m_ready) w_next_state = c_st_done;
            c_st_done: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    // Request latch, read-byte buffer and per-side read data holding registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_sel_d   <= 1'b0;
            r_last_d  <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 16'h0000;
            r_wdata   <= 16'h0000;
            r_rbuf_lo <= 8'h00;
            r_i_rdata <= 16'h0000;
            r_d_rdata <= 16'h0000;
        end else begin
            if (r_state == c_st_idle && w_grant) begin
                r_sel_d  <= w_grant_d;
                r_last_d <= w_grant_d;
                r_addr   <= w_grant_d ? d_addr : i_addr;
                r_we     <= w_grant_d & d_we;
                r_wdata  <= w_grant_d ? d_wdata : 16'h0000;
            end
            if (r_state == c_st_lo && m_ready) begin
                r_rbuf_lo <= m_rdata;
            end
            // Read data is published on entry to DONE so it is valid with the ack.
            if (r_state == c_st_hi && m_ready && !r_we) begin
                if (r_sel_d) begin
                    r_d_rdata <= {m_rdata, r_rbuf_lo};
                end else begin
                    r_i_rdata <= {m_rdata, r_rbuf_lo};
                end
            end
        end
    end

    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = 16'h0000;
        m_wdata = 8'h00;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        case (r_state)
            c_st_lo: begin
                m_req   = 1'b1;
                m_we    = r_we;
                m_addr  = r_addr;
                m_wdata = r_wdata[7:0];
            end
            c_st_hi: begin
                m_req   = 1'b1;
                m_we    = r_we;
                m_addr  = r_addr + 16'd1;
                m_wdata = r_wdata[15:8];
            end
            c_st_done: begin
                i_ack = ~r_sel_d;
                d_ack = r_sel_d;
            end
            default: ;
        endcase
    end

    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed scenarios plus a
//            randomized run against a word-level shadow memory model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic        m_ready;
    logic [7:0]  m_rdata;

    logic [7:0]  mem    [0:65535];
    logic [7:0]  shadow [0:65535];
    logic        poke_en;
    logic [15:0] poke_addr;
    logic [7:0]  poke_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ready (m_ready),
        .m_rdata (m_rdata)
    );

    // Byte memory slave: read data is combinational from the current address.
    assign m_rdata = mem[m_addr];
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (m_req && m_ready && m_we) mem[m_addr] <= m_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        shadow[a] = d;
        tick();
        poke_en = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 16'hFFFF;
        return 16'h2000 + 16'($urandom_range(0, 14));
    endfunction

    task automatic test_reset();
        n_rst = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({i_ack, d_ack, m_req, m_we, m_addr, m_wdata, i_rdata, d_rdata} !== 60'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0",
                     {i_ack, d_ack, m_req, m_we, m_addr, m_wdata, i_rdata, d_rdata});
        end
        n_rst = 1'b1;
        tick();
        n_cmp++;
        if ({i_ack, d_ack, m_req} !== 3'b000) begin
            n_err++; $display("FAIL idle_after_reset: got %b want 000", {i_ack, d_ack, m_req});
        end
    endtask

    task automatic test_d_write();
        m_ready = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
        tick();
        n_cmp++;
        if ({m_req, m_we, m_addr, m_wdata, i_ack, d_ack} !== {1'b1, 1'b1, 16'h1234, 8'hEF, 2'b00}) begin
            n_err++; $display("FAIL d_write_c1: got %h want %h", {m_req, m_we, m_addr, m_wdata, i_ack, d_ack},
                              {1'b1, 1'b1, 16'h1234, 8'hEF, 2'b00});
        end
        tick();
        n_cmp++;
        if ({m_req, m_we, m_addr, m_wdata, i_ack, d_ack} !== {1'b1, 1'b1, 16'h1235, 8'hBE, 2'b00}) begin
            n_err++; $display("FAIL d_write_c2: got %h want %h", {m_req, m_we, m_addr, m_wdata, i_ack, d_ack},
                              {1'b1, 1'b1, 16'h1235, 8'hBE, 2'b00});
        end
        tick();
        n_cmp++;
        if ({i_ack, d_ack, m_req} !== 3'b010) begin
            n_err++; $display("FAIL d_write_ack: got %b want 010", {i_ack, d_ack, m_req});
        end
        d_req = 1'b0; d_we = 1'b0;
        shadow[16'h1234] = 8'hEF; shadow[16'h1235] = 8'hBE;
        tick();
        n_cmp++;
        if ({i_ack, d_ack, m_req} !== 3'b000 || {mem[16'h1235], mem[16'h1234]} !== 16'hBEEF) begin
            n_err++; $display("FAIL d_write_done: got %b/%h want 000/beef",
                              {i_ack, d_ack, m_req}, {mem[16'h1235], mem[16'h1234]});
        end
    endtask

    task automatic test_i_wrap();
        poke(16'hFFFF, 8'h34);
        poke(16'h0000, 8'h12);
        i_req = 1'b1; i_addr = 16'hFFFF;
        tick();
        n_cmp++;
        if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 16'hFFFF}) begin
            n_err++; $display("FAIL i_wrap_lo: got %h want %h", {m_req, m_we, m_addr}, {1'b1, 1'b0, 16'hFFFF});
        end
        tick();
        n_cmp++;
        if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 16'h0000}) begin
            n_err++; $display("FAIL i_wrap_hi: got %h want %h", {m_req, m_we, m_addr}, {1'b1, 1'b0, 16'h0000});
        end
        tick();
        n_cmp++;
        if ({i_ack, d_ack, i_rdata} !== {2'b10, 16'h1234}) begin
            n_err++; $display("FAIL i_wrap_ack: got %b/%h want 10/1234", {i_ack, d_ack}, i_rdata);
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        logic exp_i;
        logic exp_d;
        n_rst = 1'b0;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 16'h0010; d_addr = 16'h0020;
        tick();
        n_rst = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp_i = (c == 7) || (c == 15);
            exp_d = (c == 3) || (c == 11);
            n_cmp++;
            if ({i_ack, d_ack} !== {exp_i, exp_d}) begin
                n_err++; $display("FAIL tie_cycle%0d: got %b want %b", c, {i_ack, d_ack}, {exp_i, exp_d});
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        poke(16'h0100, 8'h5A);
        poke(16'h0101, 8'hA5);
        m_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_cmp++;
            if (c <= 4) begin
                if ({m_req, m_addr, d_ack} !== {1'b1, 16'h0100, 1'b0}) begin
                    n_err++; $display("FAIL stall_lo_c%0d: got %h want %h", c, {m_req, m_addr, d_ack},
                                      {1'b1, 16'h0100, 1'b0});
                end
            end else if (c == 5) begin
                if ({m_req, m_addr, d_ack} !== {1'b1, 16'h0101, 1'b0}) begin
                    n_err++; $display("FAIL stall_hi: got %h want %h", {m_req, m_addr, d_ack},
                                      {1'b1, 16'h0101, 1'b0});
                end
            end else begin
                if ({d_ack, d_rdata} !== {1'b1, 16'hA55A}) begin
                    n_err++; $display("FAIL stall_ack: got %b/%h want 1/a55a", d_ack, d_rdata);
                end
            end
            if (c == 4) m_ready = 1'b1;
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100; i_addr = 16'h0200;
        tick();
        tick();
        n_cmp++;
        if (m_addr !== 16'h0101) begin
            n_err++; $display("FAIL rst_mid_in_hi: got %h want 0101", m_addr);
        end
        n_rst = 1'b0;
        tick();
        n_cmp++;
        if ({m_req, i_ack, d_ack, d_rdata} !== 19'h0) begin
            n_err++; $display("FAIL rst_mid_abort: got %b/%h want 000/0000", {m_req, i_ack, d_ack}, d_rdata);
        end
        n_rst = 1'b1; i_req = 1'b1;
        tick();
        n_cmp++;
        if ({m_req, m_addr} !== {1'b1, 16'h0100}) begin
            n_err++; $display("FAIL rst_mid_regrant: got %h want %h", {m_req, m_addr}, {1'b1, 16'h0100});
        end
        tick(); tick();
        n_cmp++;
        if ({i_ack, d_ack} !== 2'b01) begin
            n_err++; $display("FAIL rst_mid_ack: got %b want 01", {i_ack, d_ack});
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_late_d();
        poke(16'h0300, 8'h11); poke(16'h0301, 8'h22);
        poke(16'h0400, 8'h33); poke(16'h0401, 8'h44);
        m_ready = 1'b1;
        i_req = 1'b1; i_addr = 16'h0300; d_we = 1'b0; d_addr = 16'h0400;
        tick();
        tick();
        d_req = 1'b1;
        tick();
        n_cmp++;
        if ({i_ack, d_ack, i_rdata} !== {2'b10, 16'h2211}) begin
            n_err++; $display("FAIL late_i_ack: got %b/%h want 10/2211", {i_ack, d_ack}, i_rdata);
        end
        tick(); tick();
        n_cmp++;
        if ({m_req, m_addr} !== {1'b1, 16'h0400}) begin
            n_err++; $display("FAIL late_d_grant: got %h want %h", {m_req, m_addr}, {1'b1, 16'h0400});
        end
        tick(); tick();
        n_cmp++;
        if ({i_ack, d_ack, d_rdata} !== {2'b01, 16'h4433}) begin
            n_err++; $display("FAIL late_d_ack: got %b/%h want 01/4433", {i_ack, d_ack}, d_rdata);
        end
        d_req = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({m_req, m_addr} !== {1'b1, 16'h0300}) begin
            n_err++; $display("FAIL late_i_regrant: got %h want %h", {m_req, m_addr}, {1'b1, 16'h0300});
        end
        tick(); tick();
        n_cmp++;
        if ({i_ack, d_ack, i_rdata} !== {2'b10, 16'h2211}) begin
            n_err++; $display("FAIL late_i_ack2: got %b/%h want 10/2211", {i_ack, d_ack}, i_rdata);
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int          i_other;
        int          d_other;
        int          i_age;
        int          d_age;
        int          n_acks;
        logic        prev_stall;
        logic [25:0] prev_bus;
        logic [15:0] a1;
        logic [15:0] exp;
        logic        draining;
        for (int k = 0; k < 16; k++) poke(16'h2000 + 16'(k), 8'($urandom));
        poke(16'hFFFF, 8'($urandom));
        poke(16'h0000, 8'($urandom));
        i_other = 0; d_other = 0; i_age = 0; d_age = 0; n_acks = 0;
        prev_stall = 1'b0; prev_bus = '0;
        i_req = 1'b0; d_req = 1'b0;
        for (int cyc = 0; cyc < 3200; cyc++) begin
            draining = (cyc >= 3000);
            tick();
            if (prev_stall) begin
                n_cmp++;
                if ({m_req, m_we, m_addr, m_wdata} !== prev_bus) begin
                    n_err++; $display("FAIL rnd_stall_stable: got %h want %h", {m_req, m_we, m_addr, m_wdata}, prev_bus);
                end
            end
            m_ready = ($urandom_range(0, 3) != 0);
            prev_stall = m_req && !m_ready;
            prev_bus = {m_req, m_we, m_addr, m_wdata};
            if (m_req && m_we) begin
                n_cmp++;
                if (!(d_req && d_we)) begin
                    n_err++; $display("FAIL rnd_we_owner: got m_we=1 want write only for d-side write");
                end
            end
            if (i_ack && d_ack) begin
                n_cmp++; n_err++; $display("FAIL rnd_dual_ack: got 11 want at most one");
            end
            if (d_ack && i_req) i_other++;
            if (i_ack && d_req) d_other++;
            if (i_req) i_age++;
            if (d_req) d_age++;
            if (i_ack) begin
                n_acks++;
                a1 = i_addr + 16'd1;
                exp = {shadow[a1], shadow[i_addr]};
                n_cmp++;
                if (i_rdata !== exp || i_other > 1 || !i_req) begin
                    n_err++; $display("FAIL rnd_i_ack: got %h (skips %0d) want %h (skips<=1)", i_rdata, i_other, exp);
                end
                i_other = 0; i_age = 0;
                if (!draining && $urandom_range(0, 1) == 1) i_addr = rand_addr();
                else i_req = 1'b0;
            end else if (!i_req && !draining && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = rand_addr(); i_other = 0; i_age = 0;
            end
            if (d_ack) begin
                n_acks++;
                a1 = d_addr + 16'd1;
                n_cmp++;
                if (d_we) begin
                    shadow[d_addr] = d_wdata[7:0];
                    shadow[a1] = d_wdata[15:8];
                    if (d_other > 1 || !d_req) begin
                        n_err++; $display("FAIL rnd_d_wack: got skips %0d want <=1", d_other);
                    end
                end else begin
                    exp = {shadow[a1], shadow[d_addr]};
                    if (d_rdata !== exp || d_other > 1 || !d_req) begin
                        n_err++; $display("FAIL rnd_d_rack: got %h (skips %0d) want %h (skips<=1)", d_rdata, d_other, exp);
                    end
                end
                d_other = 0; d_age = 0;
                if (!draining && $urandom_range(0, 1) == 1) begin
                    d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
                end else begin
                    d_req = 1'b0;
                end
            end else if (!d_req && !draining && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1));
                d_wdata = 16'($urandom); d_other = 0; d_age = 0;
            end
            if (i_age == 100 || d_age == 100) begin
                n_cmp++; n_err++;
                $display("FAIL rnd_timeout: got request pending %0d/%0d cycles want ack within 100", i_age, d_age);
            end
            if (draining && !i_req && !d_req) break;
        end
        n_cmp++;
        if (i_req || d_req || n_acks < 200) begin
            n_err++; $display("FAIL rnd_drain: got pending %b acks %0d want none pending and >=200 acks",
                              {i_req, d_req}, n_acks);
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    initial begin
        n_rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; m_ready = 1'b0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        test_reset();
        test_d_write();
        test_i_wrap();
        test_tie();
        test_stall();
        test_reset_mid();
        test_late_d();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
